// File: rtl/imem_responder_if.sv
// Fetch bus between the core (master) and the instruction-memory responder (slave).
// The bus carries a request channel (address) and a response channel (instruction word and error flag).
interface imem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_inst;
   logic        resp_err;

   modport master (
      output req_valid, req_addr, resp_ready,
      input  req_ready, resp_valid, resp_inst, resp_err
   );

   modport slave (
      input  req_valid, req_addr, resp_ready,
      output req_ready, resp_valid, resp_inst, resp_err
   );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: word-organised store with a loader write port.
// It serves one fetch at a time, and each response arrives a fixed LATENCY cycles after the request is accepted.
// Misaligned or out-of-range fetches complete with resp_err=1 and resp_inst=0.
module imem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h80000000,
   parameter int unsigned LATENCY     = 2
) (
   input  logic               clk,
   input  logic               rst,
   imem_responder_if.slave    bus,
   input  logic               ld_we,
   input  logic [31:0]        ld_addr,
   input  logic [31:0]        ld_data,
   output logic [31:0]        fetch_cnt
);

   localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   // End of the window in 33 bits so BASE_ADDR near the top of the map cannot wrap.
   localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);
   localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state, state_next;
   logic [3:0]  cnt, cnt_next;
   logic [31:0] addr;
   logic [31:0] rd_addr;
   logic        ready, valid, enter_resp, handshake;
   logic [31:0] inst;
   logic        err;
   logic [31:0] mem [DEPTH_WORDS];

   function automatic logic addr_bad(input logic [31:0] a);
      return (a[1:0] != 2'b00) ||
             ({1'b0, a} < {1'b0, BASE_ADDR}) ||
             ({1'b0, a} >= END_ADDR);
   endfunction

   function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
      return AW'((a - BASE_ADDR) >> 2);
   endfunction

   // With LATENCY==1 the store is read on the acceptance edge, so the address comes straight off the bus.
   assign rd_addr   = (state == IDLE) ? bus.req_addr : addr;
   assign handshake = valid && bus.resp_ready;

   // Next-state and handshake outputs; the latency counter ticks down while waiting.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      ready      = 1'b0;
      valid      = 1'b0;
      enter_resp = 1'b0;
      unique case (state)
         IDLE: begin
            ready = 1'b1;
            if (bus.req_valid) begin
               if (LATENCY == 1) begin
                  state_next = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_next = WAIT;
                  cnt_next   = CNT_LOAD;
               end
            end
         end
         WAIT: begin
            cnt_next = cnt - 4'd1;
            if (cnt == 4'd1) begin
               state_next = RESP;
               enter_resp = 1'b1;
            end
         end
         RESP: begin
            valid = 1'b1;
            if (bus.resp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State register and latency counter.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Fetch address is captured only at acceptance; later bus changes are ignored.
   always_ff @(posedge clk) begin
      if (state == IDLE && bus.req_valid) addr <= bus.req_addr;
   end

   // Response capture on the edge entering RESP, held until the handshake; completed-fetch counter.
   always_ff @(posedge clk) begin
      if (!rst) begin
         inst      <= 32'd0;
         err       <= 1'b0;
         fetch_cnt <= 32'd0;
      end else begin
         if (enter_resp) begin
            err  <= addr_bad(rd_addr);
            inst <= addr_bad(rd_addr) ? 32'd0 : mem[word_idx(rd_addr)];
         end
         if (handshake) fetch_cnt <= fetch_cnt + 32'd1;
      end
   end

   // Loader port: works in every state and during reset, and drops bad addresses. A read on the same edge sees the old word.
   always_ff @(posedge clk) begin
      if (ld_we && !addr_bad(ld_addr)) mem[word_idx(ld_addr)] <= ld_data;
   end

   assign bus.req_ready  = ready;
   assign bus.resp_valid = valid;
   assign bus.resp_inst  = inst;
   assign bus.resp_err   = err;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder. dut_a is the default build (LATENCY=2, 1024 words) and is checked against a
// word-array reference model under randomized fetches and loader traffic. dut_b is a LATENCY=1,
// 16-word build that is used for back-to-back throughput checks.
module tb_imem_responder;
   localparam logic [31:0] BASE    = 32'h80000000;
   localparam int          DEPTH   = 1024;
   localparam int          LAT     = 2;
   localparam int          DEPTH_B = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   imem_responder_if a_if ();
   imem_responder_if b_if ();

   logic        ld_we_a, ld_we_b;
   logic [31:0] ld_addr_a, ld_data_a, ld_addr_b, ld_data_b;
   logic [31:0] fetch_cnt_a, fetch_cnt_b;

   imem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) dut_a (
      .clk(clk), .rst(rst), .bus(a_if),
      .ld_we(ld_we_a), .ld_addr(ld_addr_a), .ld_data(ld_data_a), .fetch_cnt(fetch_cnt_a)
   );

   imem_responder #(.DEPTH_WORDS(DEPTH_B), .BASE_ADDR(BASE), .LATENCY(1)) dut_b (
      .clk(clk), .rst(rst), .bus(b_if),
      .ld_we(ld_we_b), .ld_addr(ld_addr_b), .ld_data(ld_data_b), .fetch_cnt(fetch_cnt_b)
   );

   int          n_chk = 0;
   int          n_err = 0;
   int          exp_cnt = 0;
   logic [31:0] mdl [DEPTH];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference rules: word aligned and inside [BASE, BASE + 4*DEPTH), evaluated in 64-bit arithmetic.
   function automatic bit mdl_bad(input logic [31:0] a);
      longint x, lo;
      x  = longint'({32'b0, a});
      lo = longint'({32'b0, BASE});
      return (x % 4 != 0) || (x < lo) || (x >= lo + 4 * DEPTH);
   endfunction

   function automatic int mdl_idx(input logic [31:0] a);
      return int'((longint'({32'b0, a}) - longint'({32'b0, BASE})) / 4);
   endfunction

   function automatic logic [31:0] rand_ld_addr();
      case ($urandom_range(0, 3))
         0:       return BASE + 32'($urandom_range(0, 7)) * 4;
         1:       return BASE + 32'($urandom_range(0, DEPTH - 1)) * 4;
         2:       return BASE + 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
         default: return BASE + 32'(DEPTH) * 4 + 32'($urandom_range(0, 15)) * 4;
      endcase
   endfunction

   function automatic logic [31:0] rand_fetch_addr();
      case ($urandom_range(0, 9))
         0:       return BASE + 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
         1:       return BASE - 32'($urandom_range(1, 64)) * 4;
         2:       return BASE + 32'(DEPTH) * 4 + 32'($urandom_range(0, 64)) * 4;
         3, 4:    return BASE + 32'($urandom_range(0, DEPTH - 1)) * 4;
         default: return BASE + 32'($urandom_range(0, 7)) * 4;
      endcase
   endfunction

   task automatic drive_ld(input bit en);
      ld_we_a   = en && ($urandom_range(0, 1) == 1);
      ld_addr_a = rand_ld_addr();
      ld_data_a = $urandom();
   endtask

   // Apply the write the bench drove on the edge that just passed.
   task automatic commit_ld();
      if (ld_we_a && !mdl_bad(ld_addr_a)) mdl[mdl_idx(ld_addr_a)] = ld_data_a;
      ld_we_a = 1'b0;
   endtask

   // One complete fetch on dut_a. The response must appear LAT edges after acceptance. Its contents
   // are the model word as it stood just before the capture edge. The response is held for 'hold'
   // cycles and then consumed.
   task automatic fetch(input logic [31:0] addr, input int hold, input bit ld_rand,
                        input bit ld_last, input logic [31:0] ld_last_data);
      bit          bad;
      logic [31:0] exp_inst;
      bad      = mdl_bad(addr);
      exp_inst = 32'd0;
      a_if.req_valid = 1'b1;
      a_if.req_addr  = addr;
      check("req_ready_idle", 32'(a_if.req_ready), 32'd1);
      for (int e = 0; e < LAT; e++) begin
         a_if.resp_ready = 1'($urandom_range(0, 1));
         drive_ld(ld_rand);
         if (e == LAT - 1) begin
            if (!bad) exp_inst = mdl[mdl_idx(addr)];
            if (ld_last) begin
               ld_we_a   = 1'b1;
               ld_addr_a = addr;
               ld_data_a = ld_last_data;
            end
         end
         tick();
         commit_ld();
         if (e == 0) begin
            a_if.req_valid = 1'b0;
            a_if.req_addr  = $urandom();
         end
         if (e < LAT - 1) begin
            check("wait_resp_valid", 32'(a_if.resp_valid), 32'd0);
            check("wait_req_ready", 32'(a_if.req_ready), 32'd0);
         end
      end
      a_if.resp_ready = 1'b0;
      check("resp_valid", 32'(a_if.resp_valid), 32'd1);
      check("resp_inst", a_if.resp_inst, exp_inst);
      check("resp_err", 32'(a_if.resp_err), 32'(bad));
      check("resp_req_ready", 32'(a_if.req_ready), 32'd0);
      for (int h = 0; h < hold; h++) begin
         drive_ld(ld_rand);
         tick();
         commit_ld();
         check("hold_resp_valid", 32'(a_if.resp_valid), 32'd1);
         check("hold_resp_inst", a_if.resp_inst, exp_inst);
         check("hold_resp_err", 32'(a_if.resp_err), 32'(bad));
         check("hold_req_ready", 32'(a_if.req_ready), 32'd0);
      end
      // A request offered during the handshake cycle must not be taken.
      a_if.resp_ready = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
         a_if.req_valid = 1'b1;
         a_if.req_addr  = $urandom();
      end
      drive_ld(ld_rand);
      tick();
      commit_ld();
      exp_cnt++;
      a_if.req_valid  = 1'b0;
      a_if.resp_ready = 1'b0;
      check("hs_resp_valid", 32'(a_if.resp_valid), 32'd0);
      check("hs_req_ready", 32'(a_if.req_ready), 32'd1);
      check("fetch_cnt", fetch_cnt_a, 32'(exp_cnt));
   endtask

   initial begin
      rst = 1'b0;
      a_if.req_valid = 1'b0; a_if.req_addr = 32'd0; a_if.resp_ready = 1'b0;
      b_if.req_valid = 1'b0; b_if.req_addr = 32'd0; b_if.resp_ready = 1'b0;
      ld_we_a = 1'b0; ld_addr_a = 32'd0; ld_data_a = 32'd0;
      ld_we_b = 1'b0; ld_addr_b = 32'd0; ld_data_b = 32'd0;
      tick();
      tick();
      check("rst_req_ready", 32'(a_if.req_ready), 32'd1);
      check("rst_resp_valid", 32'(a_if.resp_valid), 32'd0);
      check("rst_resp_inst", a_if.resp_inst, 32'd0);
      check("rst_resp_err", 32'(a_if.resp_err), 32'd0);
      check("rst_fetch_cnt", fetch_cnt_a, 32'd0);
      check("rst_b_fetch_cnt", fetch_cnt_b, 32'd0);
      rst = 1'b1;

      // Preload every word of dut_a; word 0 holds the ebreak encoding.
      for (int i = 0; i < DEPTH; i++) begin
         ld_we_a   = 1'b1;
         ld_addr_a = BASE + 32'(i) * 4;
         ld_data_a = (i == 0) ? 32'h00100073 : $urandom();
         tick();
         commit_ld();
      end

      // LATENCY=1 build: back-to-back fetches, one accepted every 2 cycles.
      ld_we_b = 1'b1; ld_addr_b = BASE;     ld_data_b = 32'hA5A50001; tick();
      ld_addr_b = BASE + 4; ld_data_b = 32'h5A5A0002; tick();
      ld_we_b = 1'b0;
      b_if.resp_ready = 1'b1;
      b_if.req_valid  = 1'b1;
      b_if.req_addr   = BASE;
      tick();
      check("b_valid1", 32'(b_if.resp_valid), 32'd1);
      check("b_inst1", b_if.resp_inst, 32'hA5A50001);
      check("b_err1", 32'(b_if.resp_err), 32'd0);
      check("b_req_ready1", 32'(b_if.req_ready), 32'd0);
      b_if.req_addr = BASE + 4;
      tick();
      check("b_hs1_valid", 32'(b_if.resp_valid), 32'd0);
      check("b_hs1_ready", 32'(b_if.req_ready), 32'd1);
      check("b_cnt1", fetch_cnt_b, 32'd1);
      tick();
      check("b_valid2", 32'(b_if.resp_valid), 32'd1);
      check("b_inst2", b_if.resp_inst, 32'h5A5A0002);
      b_if.req_addr = BASE + 32'(DEPTH_B) * 4;
      tick();
      check("b_cnt2", fetch_cnt_b, 32'd2);
      check("b_hs2_valid", 32'(b_if.resp_valid), 32'd0);
      tick();
      b_if.req_valid = 1'b0;
      check("b_oor_err", 32'(b_if.resp_err), 32'd1);
      check("b_oor_inst", b_if.resp_inst, 32'd0);
      tick();
      check("b_cnt3", fetch_cnt_b, 32'd3);
      b_if.resp_ready = 1'b0;

      // Directed fetches on dut_a: first fetch, backpressure, error cases, read-before-write.
      fetch(BASE, 0, 1'b0, 1'b0, 32'd0);
      check("first_inst_value", mdl[0], 32'h00100073);
      fetch(BASE + 8, 5, 1'b0, 1'b0, 32'd0);
      fetch(BASE + 2, 1, 1'b0, 1'b0, 32'd0);
      fetch(32'h7FFFFFFC, 0, 1'b0, 1'b0, 32'd0);
      fetch(BASE + 32'(DEPTH) * 4, 0, 1'b0, 1'b0, 32'd0);
      fetch(32'hFFFFFFFC, 0, 1'b0, 1'b0, 32'd0);
      fetch(32'h00000000, 0, 1'b0, 1'b0, 32'd0);
      fetch(BASE + 12, 0, 1'b0, 1'b1, 32'hDEADBEEF);
      fetch(BASE + 12, 0, 1'b0, 1'b0, 32'd0);
      check("rbw_new_value", a_if.resp_inst, 32'hDEADBEEF);

      // Reset while a fetch is waiting; a loader write issued during reset must still land.
      a_if.req_valid = 1'b1;
      a_if.req_addr  = BASE + 16;
      tick();
      a_if.req_valid = 1'b0;
      check("midrst_in_wait", 32'(a_if.req_ready), 32'd0);
      rst       = 1'b0;
      ld_we_a   = 1'b1;
      ld_addr_a = BASE + 20;
      ld_data_a = 32'h12345678;
      tick();
      commit_ld();
      rst     = 1'b1;
      exp_cnt = 0;
      a_if.resp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("midrst_resp_valid", 32'(a_if.resp_valid), 32'd0);
         check("midrst_req_ready", 32'(a_if.req_ready), 32'd1);
         check("midrst_fetch_cnt", fetch_cnt_a, 32'd0);
         tick();
      end
      a_if.resp_ready = 1'b0;
      fetch(BASE + 16, 0, 1'b0, 1'b0, 32'd0);
      fetch(BASE + 20, 0, 1'b0, 1'b0, 32'd0);
      check("ld_during_rst", mdl[5], 32'h12345678);
      fetch(BASE, 0, 1'b0, 1'b0, 32'd0);

      // Randomized fetches with concurrent loader traffic and idle gaps.
      for (int n = 0; n < 300; n++) begin
         fetch(rand_fetch_addr(), int'($urandom_range(0, 3)), 1'b1, 1'b0, 32'd0);
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
            a_if.resp_ready = 1'($urandom_range(0, 1));
            drive_ld(1'b1);
            tick();
            commit_ld();
            check("gap_resp_valid", 32'(a_if.resp_valid), 32'd0);
            check("gap_fetch_cnt", fetch_cnt_a, 32'(exp_cnt));
         end
         a_if.resp_ready = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
